rsa_exp_arbiter: RTL and testbench
==================================

// Module: rsa_exp_arbiter
// PURPOSE
//  Shares the single montgomery_exp engine between NUM_REQ requesters (e.g. encrypt and decrypt channels).
//  Arbitrates round-robin, latches the winner's operands, and sequences engine reset/enable.
//  Returns the result (or a timeout error) to the owning requester.
//  Sits between the requester front-ends and montgomery_exp. Drives the engine's reset/enable/m/x/e/t.
// PARAMETERS
//  WORD_WIDTH     32    operand/result width; equals the engine's WORD_WIDTH
//  NUM_REQ        2     number of requesters, >=1
//  TIMEOUT_CYCLES 4096  max RUN cycles before the job is aborted, >=2
// PORTS
//  clk          in   1                          clock, rising edge
//  rst          in   1                          reset, asynchronous, active-high
//  req_valid    in   NUM_REQ                    per-requester job request; held high until req_ready
//  req_ready    out  NUM_REQ                    one-hot accept pulse; transfer when valid&ready
//  req_base     in   NUM_REQ*WORD_WIDTH         flattened base x; slice i belongs to requester i
//  req_exp      in   NUM_REQ*WORD_WIDTH         flattened exponent e
//  req_exp_msb  in   NUM_REQ*$clog2(WORD_WIDTH) flattened MSB index t of the exponent
//  req_mod      in   NUM_REQ*WORD_WIDTH         flattened odd modulus m
//  rsp_valid    out  NUM_REQ                    one-hot, one-cycle response strobe
//  rsp_data     out  WORD_WIDTH                 result; valid while any rsp_valid bit is high
//  rsp_error    out  1                          1 = job timed out; rsp_data is then 0
//  busy         out  1                          high in every state except IDLE
//  eng_rst      out  1                          engine reset
//  eng_enable   out  1                          engine enable/start
//  eng_done     in   1                          engine completion
//  eng_m/eng_x/eng_e out WORD_WIDTH             latched modulus, base and exponent
//  eng_t        out  $clog2(WORD_WIDTH)         latched exponent MSB index
//  eng_result   in   WORD_WIDTH                 engine result
// BEHAVIOUR
//  Output drive and reset values
//  - All outputs come from flops or from state-register decode only; none depend combinationally on inputs.
//  - On rst: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, busy=0.
//  - Also on rst: eng_rst=1, eng_enable=0, eng_m/x/e/t=0, owner=0, last_owner=NUM_REQ-1, timer=0.
//  - The engine is held in reset (eng_rst=1) in every state except RUN.
//  FSM: IDLE -> GRANT -> RUN -> RESP -> IDLE
//  - IDLE: if |req_valid, pick the winner round-robin and register it as owner; go to GRANT.
//    Priority starts at (last_owner+1) mod NUM_REQ, wrapping.
//  - GRANT (1 cycle): req_ready[owner]=1, eng_rst=1.
//    At the end of this cycle, latch the owner's slices into eng_m/x/e/t, set last_owner=owner, clear the timer.
//  - RUN: eng_rst=0, eng_enable=1, timer increments each cycle.
//    If eng_done=1: rsp_data<=eng_result, rsp_error<=0, go to RESP.
//    Else if timer==TIMEOUT_CYCLES-1: rsp_data<=0, rsp_error<=1, go to RESP.
//    If eng_done and timeout coincide, done wins.
//  - RESP (1 cycle): rsp_valid[owner]=1, eng_enable=0, eng_rst=1; go to IDLE.
//    rsp_data/rsp_error hold their value until the next RESP.
//  Latency
//  - Request seen in IDLE at cycle 0: req_ready at cycle 1, eng_enable from cycle 2.
//  - eng_done sampled at cycle k gives rsp_valid at cycle k+1.
//  - Minimum gap between jobs: the one IDLE cycle.
//  Boundary conditions
//  - Requests arriving while busy wait; there is no queue beyond req_valid itself.
//  - Latched operands are immune to input changes after GRANT.
//  - NUM_REQ=1: always grant requester 0.
//  - rst mid-job: the job is dropped with no rsp_valid; all values return to their reset values asynchronously.
//  - eng_done outside RUN is ignored.
//  - The timer has $clog2(TIMEOUT_CYCLES) bits and never wraps.
// TESTING
//  1. Real montgomery_exp: req0 base=5, exp=3, t=1, mod=33 -> rsp_valid[0], rsp_data=26, rsp_error=0;
//     req_ready[0] exactly 1 cycle after valid.
//  2. Stub engine, done after 4 cycles. Both valid in the first cycle after reset ->
//     req0 served first, then req1; rsp_valid strobes are one-hot, one cycle each.
//  3. Stub engine: req0 and req1 held continuously for 4 jobs -> grant order 0,1,0,1; no starvation.
//  4. TIMEOUT_CYCLES=16, stub never raises done -> rsp_error=1, rsp_data=0;
//     eng_enable is high exactly 16 cycles; the following req1 job completes normally.
//  5. rst pulsed during RUN -> next edge shows all reset values, no rsp_valid.
//     After release, both valid -> req0 granted first.
//  6. Stub raises eng_done on the timeout cycle (timer=15 with TIMEOUT_CYCLES=16) ->
//     rsp_error=0, rsp_data=eng_result; changing req_base during RUN does not alter eng_x.

Source files
------------

// File: rtl/rsa_exp_arbiter.sv
// rsa_exp_arbiter: round-robin front end that shares one montgomery_exp engine between requesters.
// Latches the winner's operands, sequences engine reset/enable and returns the result or a timeout error.
module rsa_exp_arbiter #(
    parameter int WORD_WIDTH     = 32,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]         req_base,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]         req_exp,
    input  logic [NUM_REQ*$clog2(WORD_WIDTH)-1:0] req_exp_msb,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]         req_mod,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [WORD_WIDTH-1:0]                 rsp_data,
    output logic                                  rsp_error,
    output logic                                  busy,
    output logic                                  eng_rst,
    output logic                                  eng_enable,
    input  logic                                  eng_done,
    output logic [WORD_WIDTH-1:0]                 eng_m,
    output logic [WORD_WIDTH-1:0]                 eng_x,
    output logic [WORD_WIDTH-1:0]                 eng_e,
    output logic [$clog2(WORD_WIDTH)-1:0]         eng_t,
    input  logic [WORD_WIDTH-1:0]                 eng_result
);
    localparam int T_W     = $clog2(WORD_WIDTH);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   OWNER_RST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDX_W-1:0]     owner_r;
    logic [IDX_W-1:0]     last_owner_r;
    logic [TIMER_W-1:0]   timer_r;
    logic                 timeout_s;
    logic                 any_req_s;
    logic                 found_s;
    logic [IDX_W-1:0]     cand_s;
    logic [IDX_W-1:0]     winner_s;
    logic [NUM_REQ-1:0]   owner_onehot_s;
    logic [WORD_WIDTH-1:0] sel_base_s;
    logic [WORD_WIDTH-1:0] sel_exp_s;
    logic [WORD_WIDTH-1:0] sel_mod_s;
    logic [T_W-1:0]       sel_msb_s;

    assign any_req_s = |req_valid;
    assign timeout_s = (timer_r == TIMER_LAST);

    // Round-robin pick: scan from last_owner+1 upward, wrapping, first valid requester wins.
    always_comb begin
        found_s  = 1'b0;
        cand_s   = last_owner_r;
        winner_s = last_owner_r;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s   = IDX_W'((int'(last_owner_r) + k) % NUM_REQ);
            winner_s = (!found_s && req_valid[cand_s]) ? cand_s : winner_s;
            found_s  = found_s | req_valid[cand_s];
        end
    end

    // Owner decode: one-hot strobe vector and the owner's operand slices.
    always_comb begin
        owner_onehot_s = '0;
        sel_base_s     = '0;
        sel_exp_s      = '0;
        sel_mod_s      = '0;
        sel_msb_s      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_onehot_s[i] = (owner_r == IDX_W'(i));
            sel_base_s = (owner_r == IDX_W'(i)) ? req_base[i*WORD_WIDTH +: WORD_WIDTH] : sel_base_s;
            sel_exp_s  = (owner_r == IDX_W'(i)) ? req_exp[i*WORD_WIDTH +: WORD_WIDTH]  : sel_exp_s;
            sel_mod_s  = (owner_r == IDX_W'(i)) ? req_mod[i*WORD_WIDTH +: WORD_WIDTH]  : sel_mod_s;
            sel_msb_s  = (owner_r == IDX_W'(i)) ? req_exp_msb[i*T_W +: T_W]            : sel_msb_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a completion coinciding with the last timer cycle counts as done.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: state_nxt_s = RUN;
            RUN: begin
                if (eng_done || timeout_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from state and the registered owner only.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        busy       = 1'b1;
        eng_rst    = 1'b1;
        eng_enable = 1'b0;
        case (state_r)
            IDLE:  busy = 1'b0;
            GRANT: req_ready = owner_onehot_s;
            RUN: begin
                eng_rst    = 1'b0;
                eng_enable = 1'b1;
            end
            RESP:    rsp_valid = owner_onehot_s;
            default: busy = 1'b0;
        endcase
    end

    // Datapath: owner capture, operand latch, saturating job timer and response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r      <= '0;
            last_owner_r <= OWNER_RST;
            timer_r      <= '0;
            eng_m        <= '0;
            eng_x        <= '0;
            eng_e        <= '0;
            eng_t        <= '0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        owner_r <= winner_s;
                    end
                end
                GRANT: begin
                    eng_m        <= sel_mod_s;
                    eng_x        <= sel_base_s;
                    eng_e        <= sel_exp_s;
                    eng_t        <= sel_msb_s;
                    last_owner_r <= owner_r;
                    timer_r      <= '0;
                end
                RUN: begin
                    if (!timeout_s) begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                    if (eng_done) begin
                        rsp_data  <= eng_result;
                        rsp_error <= 1'b0;
                    end else if (timeout_s) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_exp_arbiter.sv
// Self-checking bench for rsa_exp_arbiter with a behavioural modexp engine stub and a response scoreboard.
module tb_rsa_exp_arbiter;
    localparam int WW = 32;
    localparam int NR = 2;
    localparam int TO = 16;
    localparam int TW = 5;

    typedef struct {
        int            owner;
        logic [WW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR-1:0]       rsp_valid;
    logic [WW-1:0]       base_a [NR];
    logic [WW-1:0]       exp_a  [NR];
    logic [WW-1:0]       mod_a  [NR];
    logic [TW-1:0]       msb_a  [NR];
    logic [NR*WW-1:0]    req_base;
    logic [NR*WW-1:0]    req_exp;
    logic [NR*WW-1:0]    req_mod;
    logic [NR*TW-1:0]    req_exp_msb;
    logic [WW-1:0]       rsp_data;
    logic                rsp_error;
    logic                busy;
    logic                eng_rst;
    logic                eng_enable;
    logic                eng_done;
    logic [WW-1:0]       eng_m;
    logic [WW-1:0]       eng_x;
    logic [WW-1:0]       eng_e;
    logic [TW-1:0]       eng_t;
    logic [WW-1:0]       eng_result;

    int   checks = 0;
    int   errors = 0;
    int   stub_cnt;
    int   done_at;
    logic done_force;
    bit   expect_timeout;
    exp_t sb[$];

    assign req_base    = {base_a[1], base_a[0]};
    assign req_exp     = {exp_a[1], exp_a[0]};
    assign req_mod     = {mod_a[1], mod_a[0]};
    assign req_exp_msb = {msb_a[1], msb_a[0]};

    function automatic logic [WW-1:0] modexp(input logic [WW-1:0] b, input logic [WW-1:0] e,
                                             input logic [WW-1:0] m);
        logic [63:0] r;
        logic [63:0] bb;
        if (m == '0) return '0;
        r  = 64'd1 % {32'd0, m};
        bb = {32'd0, b} % {32'd0, m};
        for (int i = 0; i < WW; i++) begin
            if (e[i]) r = (r * bb) % {32'd0, m};
            bb = (bb * bb) % {32'd0, m};
        end
        return r[WW-1:0];
    endfunction

    function automatic logic [NR-1:0] onehot(input int idx);
        logic [NR-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Engine stub: counts enabled cycles since its reset and raises done at done_at.
    always @(posedge clk or posedge rst) begin
        if (rst || eng_rst) stub_cnt <= 0;
        else if (eng_enable) stub_cnt <= stub_cnt + 1;
    end
    assign eng_done   = (eng_enable && (stub_cnt == done_at)) || done_force;
    assign eng_result = modexp(eng_x, eng_e, eng_m);

    rsa_exp_arbiter #(.WORD_WIDTH(WW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_exp(req_exp), .req_exp_msb(req_exp_msb), .req_mod(req_mod),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy),
        .eng_rst(eng_rst), .eng_enable(eng_enable), .eng_done(eng_done),
        .eng_m(eng_m), .eng_x(eng_x), .eng_e(eng_e), .eng_t(eng_t), .eng_result(eng_result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Wait (bounded) for the grant, push the expected response, then step into RUN.
    task automatic do_grant(input int want, input bit hold, output int lat);
        exp_t e;
        lat = 0;
        while (req_ready == '0 && lat < 40) begin
            tick();
            lat++;
        end
        check("grant_owner", req_ready, onehot(want));
        check("grant_eng_rst", eng_rst, 1);
        check("grant_busy", busy, 1);
        e.owner = want;
        e.err   = expect_timeout;
        e.data  = expect_timeout ? '0 : modexp(base_a[want], exp_a[want], mod_a[want]);
        sb.push_back(e);
        tick();
        if (!hold) req_valid[want] = 1'b0;
        check("run_eng_enable", eng_enable, 1);
        check("run_eng_rst", eng_rst, 0);
        check("run_eng_x", eng_x, base_a[want]);
        check("run_eng_m", eng_m, mod_a[want]);
    endtask

    // Wait (bounded) for the response strobe, counting enabled cycles, and score it.
    task automatic get_rsp(output int en_cnt);
        exp_t e;
        int   waited;
        waited = 0;
        en_cnt = 0;
        while (rsp_valid == '0 && waited < 60) begin
            if (eng_enable) en_cnt++;
            tick();
            waited++;
        end
        check("sb_pending", sb.size(), 1);
        e.owner = 0;
        e.data  = '0;
        e.err   = 1'b0;
        if (sb.size() > 0) e = sb.pop_front();
        check("rsp_valid", rsp_valid, onehot(e.owner));
        check("rsp_data", rsp_data, e.data);
        check("rsp_error", rsp_error, e.err);
        check("rsp_eng_rst", eng_rst, 1);
        check("rsp_eng_enable", eng_enable, 0);
        tick();
        check("rsp_one_cycle", rsp_valid, 0);
        check("idle_busy", busy, 0);
        check("rsp_data_hold", rsp_data, e.data);
    endtask

    initial begin
        int lat;
        int en;
        rst = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            base_a[i] = '0;
            exp_a[i]  = '0;
            mod_a[i]  = '0;
            msb_a[i]  = '0;
        end
        done_at = 3;
        done_force = 1'b0;
        expect_timeout = 1'b0;
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_rst", eng_rst, 1);
        check("rst_eng_enable", eng_enable, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_eng_m", eng_m, 0);
        rst = 1'b0;
        tick();

        // 1: single job 5^3 mod 33, grant one cycle after valid
        base_a[0] = 32'd5; exp_a[0] = 32'd3; msb_a[0] = 5'd1; mod_a[0] = 32'd33;
        req_valid = 2'b01;
        check("t1_ready_before", req_ready, 0);
        do_grant(0, 1'b0, lat);
        check("t1_latency", lat, 1);
        check("t1_eng_e", eng_e, 3);
        check("t1_eng_t", eng_t, 1);
        get_rsp(en);
        check("t1_result", rsp_data, 32'd26);

        // 2: both valid right after reset -> 0 then 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base_a[1] = 32'd7; exp_a[1] = 32'd13; msb_a[1] = 5'd3; mod_a[1] = 32'd101;
        req_valid = 2'b11;
        do_grant(0, 1'b0, lat);
        check("t2_latency0", lat, 1);
        get_rsp(en);
        check("t2_enable_cycles", en, 4);
        do_grant(1, 1'b0, lat);
        check("t2_latency1", lat, 1);
        get_rsp(en);

        // 3: both held for four jobs -> 0,1,0,1
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            do_grant(j % 2, (j < 2), lat);
            check("t3_gap", lat, 1);
            get_rsp(en);
        end

        // 4: engine never completes -> timeout, then a normal job on req1
        expect_timeout = 1'b1;
        done_at = 1000;
        base_a[0] = 32'd11; exp_a[0] = 32'd9; msb_a[0] = 5'd3; mod_a[0] = 32'd97;
        req_valid = 2'b01;
        do_grant(0, 1'b0, lat);
        get_rsp(en);
        check("t4_enable_cycles", en, TO);
        expect_timeout = 1'b0;
        done_at = 3;
        req_valid = 2'b10;
        do_grant(1, 1'b0, lat);
        get_rsp(en);
        check("t4_after_timeout_cycles", en, 4);

        // 5: reset in RUN drops the job
        req_valid = 2'b01;
        do_grant(0, 1'b0, lat);
        tick();
        rst = 1'b1;
        #1;
        check("t5_async_busy", busy, 0);
        check("t5_async_eng_rst", eng_rst, 1);
        tick();
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_eng_enable", eng_enable, 0);
        check("t5_eng_x", eng_x, 0);
        check("t5_rsp_data", rsp_data, 0);
        check("t5_rsp_error", rsp_error, 0);
        sb.delete();
        rst = 1'b0;
        req_valid = 2'b11;
        do_grant(0, 1'b0, lat);
        get_rsp(en);
        do_grant(1, 1'b0, lat);
        get_rsp(en);

        // 6: done on the final timer cycle wins; operands latched
        done_at = 15;
        base_a[0] = 32'd7; exp_a[0] = 32'd5; msb_a[0] = 5'd2; mod_a[0] = 32'd55;
        req_valid = 2'b01;
        do_grant(0, 1'b0, lat);
        base_a[0] = 32'd9;
        get_rsp(en);
        check("t6_enable_cycles", en, TO);
        check("t6_result", rsp_data, 32'd32);
        check("t6_eng_x_latched", eng_x, 32'd7);

        // eng_done outside RUN is ignored
        done_force = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("idle_done_rsp", rsp_valid, 0);
            check("idle_done_busy", busy, 0);
        end
        done_force = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
